// File: rtl/iter_mult_writeback.sv
// iter_mult_writeback: multi-cycle shift-add multiplier for MULT/MULTU.
// Computes a full 2*WIDTH product on magnitudes, fixes the sign at the end,
// and drives a one-cycle write into the register bank (low word on
// writeData, high word on highData). Latency is fixed and data independent.
module iter_mult_writeback #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signedMode,
  input  logic [WIDTH-1:0]  opA,
  input  logic [WIDTH-1:0]  opB,
  input  logic [ADDR_W-1:0] destAdd,
  output logic              busy,
  output logic              done,
  output logic [1:0]        RegWrite,
  output logic [ADDR_W-1:0] writeAdd,
  output logic [WIDTH-1:0]  writeData,
  output logic [WIDTH-1:0]  highData
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W    = 1;
  localparam logic [2*WIDTH-1:0] ONE_P    = 1;
  localparam logic [CNT_W-1:0]   CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,      state_d;
  logic [CNT_W-1:0]   cnt_q,        cnt_d;
  logic [2*WIDTH-1:0] mcand_q,      mcand_d;
  logic [WIDTH-1:0]   mplr_q,       mplr_d;
  logic [2*WIDTH-1:0] acc_q,        acc_d;
  logic               neg_q,        neg_d;
  logic [ADDR_W-1:0]  dest_q,       dest_d;
  logic               done_q,       done_d;
  logic [1:0]         reg_write_q,  reg_write_d;
  logic [ADDR_W-1:0]  write_add_q,  write_add_d;
  logic [WIDTH-1:0]   write_data_q, write_data_d;
  logic [WIDTH-1:0]   high_data_q,  high_data_d;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] product;

  // Operand magnitudes; 0x80..0 maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    mag_a = opA;
    mag_b = opB;
    if (signedMode && opA[WIDTH-1]) mag_a = ~opA + ONE_W;
    if (signedMode && opB[WIDTH-1]) mag_b = ~opB + ONE_W;
  end

  // Next-state logic: latch on start, one shift-add step per RUN cycle, publish in FIN.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcand_d      = mcand_q;
    mplr_d       = mplr_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    dest_d       = dest_q;
    done_d       = 1'b0;
    reg_write_d  = 2'd0;
    write_add_d  = write_add_q;
    write_data_d = write_data_q;
    high_data_d  = high_data_q;
    product      = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mcand_d = {{WIDTH{1'b0}}, mag_a};
          mplr_d  = mag_b;
          dest_d  = destAdd;
          neg_d   = signedMode & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (mplr_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = FIN;
      end
      FIN: begin
        state_d      = IDLE;
        product      = neg_q ? (~acc_q + ONE_P) : acc_q;
        write_data_d = product[WIDTH-1:0];
        high_data_d  = product[2*WIDTH-1:WIDTH];
        write_add_d  = dest_q;
        done_d       = 1'b1;
        reg_write_d  = (dest_q != '0) ? 2'd2 : 2'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplr_q       <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      dest_q       <= '0;
      done_q       <= 1'b0;
      reg_write_q  <= 2'd0;
      write_add_q  <= '0;
      write_data_q <= '0;
      high_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcand_q      <= mcand_d;
      mplr_q       <= mplr_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      dest_q       <= dest_d;
      done_q       <= done_d;
      reg_write_q  <= reg_write_d;
      write_add_q  <= write_add_d;
      write_data_q <= write_data_d;
      high_data_q  <= high_data_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == FIN);
  assign done      = done_q;
  assign RegWrite  = reg_write_q;
  assign writeAdd  = write_add_q;
  assign writeData = write_data_q;
  assign highData  = high_data_q;

endmodule

// File: tb/tb_iter_mult_writeback.sv
// tb_iter_mult_writeback: scoreboard bench for the iterative multiplier.
// Expected bank writes are queued when an op is issued and popped on done.
module tb_iter_mult_writeback;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signedMode;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [4:0]  destAdd;
  logic        busy;
  logic        done;
  logic [1:0]  RegWrite;
  logic [4:0]  writeAdd;
  logic [31:0] writeData;
  logic [31:0] highData;

  typedef struct packed {
    logic [1:0]  rw;
    logic [4:0]  addr;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total;
  int   bad;
  int   cyc;
  bit   seen;

  iter_mult_writeback #(.WIDTH(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signedMode (signedMode),
    .opA        (opA),
    .opB        (opB),
    .destAdd    (destAdd),
    .busy       (busy),
    .done       (done),
    .RegWrite   (RegWrite),
    .writeAdd   (writeAdd),
    .writeData  (writeData),
    .highData   (highData)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product using the simulator's own multiply
  function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b,
                                                input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sbv;
    if (s) begin
      sa  = {{32{a[31]}}, a};
      sbv = {{32{b[31]}}, b};
      return 64'(sa * sbv);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Called at a falling edge: drive start for one cycle, queue the expected write
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [4:0] d, input logic [63:0] prod);
    exp_t x;
    start      = 1'b1;
    opA        = a;
    opB        = b;
    signedMode = s;
    destAdd    = d;
    x.rw   = (d != 5'd0) ? 2'd2 : 2'd0;
    x.addr = d;
    x.hi   = prod[63:32];
    x.lo   = prod[31:0];
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    opA   = 32'd0;
    opB   = 32'd0;
  endtask

  // Wait (bounded) for done, sampling on falling edges
  task automatic wait_done(input int limit, output int cycles, output bit got);
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, RegWrite, writeAdd, writeData, highData} !== 73'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b rw=%0d wa=%0d wd=%h hd=%h expected all 0",
               busy, done, RegWrite, writeAdd, writeData, highData);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    issue(32'd18, 32'd7, 1'b0, 5'd8, 64'd126);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t1_busy got %b expected 1", busy);
    end
    wait_done(40, cyc, seen);
    total++;
    if (!seen || cyc != 33) begin
      bad++;
      $display("[TB] FAIL t1_latency got cycles=%0d seen=%0d expected 33", cyc, seen);
    end
    e = sb.pop_front();
    total++;
    if ({busy, RegWrite, writeAdd, highData, writeData} !== {1'b0, e}) begin
      bad++;
      $display("[TB] FAIL t1_result got %h expected %h", {busy, RegWrite, writeAdd, highData, writeData}, {1'b0, e});
    end
    @(negedge clk);
    total++;
    if ({done, RegWrite, writeAdd, writeData, highData} !== {1'b0, 2'd0, 5'd8, 32'd126, 32'd0}) begin
      bad++;
      $display("[TB] FAIL t1_hold got done=%b rw=%0d wa=%0d wd=%h hd=%h expected 0 0 8 126 0",
               done, RegWrite, writeAdd, writeData, highData);
    end

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd3, 64'hFFFF_FFFE_0000_0001);
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {RegWrite, writeAdd, highData, writeData} !== e) begin
      bad++;
      $display("[TB] FAIL t2_max_unsigned got %h seen=%0d expected %h",
               {RegWrite, writeAdd, highData, writeData}, seen, e);
    end
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [63:0] p [3];
    a[0] = 32'hFFFF_FFFD; b[0] = 32'd5;        p[0] = 64'hFFFF_FFFF_FFFF_FFF1;
    a[1] = 32'h8000_0000; b[1] = 32'h8000_0000; p[1] = 64'h4000_0000_0000_0000;
    a[2] = 32'h8000_0000; b[2] = 32'd1;        p[2] = 64'hFFFF_FFFF_8000_0000;
    for (int i = 0; i < 3; i++) begin
      issue(a[i], b[i], 1'b1, 5'(10 + i), p[i]);
      wait_done(40, cyc, seen);
      e = sb.pop_front();
      total++;
      if (!seen || cyc != 33 || {RegWrite, writeAdd, highData, writeData} !== e) begin
        bad++;
        $display("[TB] FAIL signed_case%0d got %h cycles=%0d expected %h after 33",
                 i, {RegWrite, writeAdd, highData, writeData}, cyc, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_busy_reset();
    issue(32'd18, 32'd7, 1'b0, 5'd8, 64'd126);
    repeat (4) @(negedge clk);
    start = 1'b1;
    opA   = 32'd9;
    opB   = 32'd7;
    destAdd = 5'd8;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL t5_busy_mid got %b expected 1", busy);
    end
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != 28 || {RegWrite, writeAdd, highData, writeData} !== e) begin
      bad++;
      $display("[TB] FAIL t5_ignored_start got %h cycles=%0d expected %h after 28",
               {RegWrite, writeAdd, highData, writeData}, cyc, e);
    end

    issue(32'd5, 32'd6, 1'b0, 5'd4, 64'd30);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, RegWrite, writeData, highData} !== 68'd0) begin
      bad++;
      $display("[TB] FAIL t5_async_reset got busy=%b done=%b rw=%0d wd=%h hd=%h expected all 0",
               busy, done, RegWrite, writeData, highData);
    end
    void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    wait_done(45, cyc, seen);
    total++;
    if (seen || RegWrite !== 2'd0) begin
      bad++;
      $display("[TB] FAIL t5_no_write_after_abort got done_seen=%0d rw=%0d expected 0 0", seen, RegWrite);
    end

    issue(32'd11, 32'd13, 1'b0, 5'd9, 64'd143);
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != 33 || {RegWrite, writeAdd, highData, writeData} !== e) begin
      bad++;
      $display("[TB] FAIL t5_recover got %h cycles=%0d expected %h after 33",
               {RegWrite, writeAdd, highData, writeData}, cyc, e);
    end
    @(negedge clk);
  endtask

  task automatic test_dest_zero();
    issue(32'd4, 32'd4, 1'b0, 5'd0, 64'd16);
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    total++;
    if (!seen || {RegWrite, writeAdd, highData, writeData} !== e) begin
      bad++;
      $display("[TB] FAIL t6_dest_zero got %h seen=%0d expected %h",
               {RegWrite, writeAdd, highData, writeData}, seen, e);
    end
    issue(32'd3, 32'd5, 1'b0, 5'd2, 64'd15);
    wait_done(40, cyc, seen);
    e = sb.pop_front();
    total++;
    if (!seen || cyc != 33 || {RegWrite, writeAdd, highData, writeData} !== e) begin
      bad++;
      $display("[TB] FAIL t6_start_in_done got %h cycles=%0d expected %h after 33 (34 after prior done)",
               {RegWrite, writeAdd, highData, writeData}, cyc, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    a = $urandom;
    b = $urandom;
    s = 1'($urandom_range(0, 1));
    issue(a, b, s, 5'($urandom_range(1, 31)), model_product(a, b, s));
    for (int i = 0; i < 6; i++) begin
      wait_done(40, cyc, seen);
      e = sb.pop_front();
      total++;
      if (!seen || cyc != 33 || {RegWrite, writeAdd, highData, writeData} !== e) begin
        bad++;
        $display("[TB] FAIL b2b_op%0d got %h cycles=%0d expected %h after 33",
                 i, {RegWrite, writeAdd, highData, writeData}, cyc, e);
      end
      if (i < 5) begin
        a = $urandom;
        b = $urandom;
        s = 1'($urandom_range(0, 1));
        issue(a, b, s, 5'($urandom_range(1, 31)), model_product(a, b, s));
      end
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
  endtask

  // Test sequence
  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    start      = 1'b0;
    signedMode = 1'b0;
    opA        = 32'd0;
    opB        = 32'd0;
    destAdd    = 5'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_busy_reset();
    test_dest_zero();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
